// File: rtl/profile_timer_mc.sv
// profile_timer_mc: NUM_CH interval/profiling counters behind an Avalon-MM slave; PROFILE_TIMER_PRESCALER_EN adds per-channel prescalers.
// Latency: readdata one cycle after the address is sampled; no backpressure, every access completes in one cycle.
module profile_timer_mc #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter logic [63:0] DEFAULT_PERIOD = 64'd49999,
  parameter int          ADDR_W         = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;

  localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] snap   [NUM_CH];
  logic [63:0]      period_wide [NUM_CH];
  logic [63:0]      snap_wide   [NUM_CH];

  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] to;
  logic [NUM_CH-1:0] ito;
  logic [NUM_CH-1:0] cont;
  logic [NUM_CH-1:0] dir;
  logic [NUM_CH-1:0] force_reload;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] term_evt;
  logic [NUM_CH-1:0] wr_hit;

`ifdef PROFILE_TIMER_PRESCALER_EN
  logic [15:0] prescale [NUM_CH];
  logic [15:0] pcnt     [NUM_CH];
`endif

  logic        wr;
  logic [7:0]  sel_ch;
  logic [2:0]  sel_reg;
  logic [31:0] rd_val;

  assign wr      = chipselect & ~write_n;
  assign sel_ch  = 8'(address >> 3);
  assign sel_reg = address[2:0];
  assign irq     = |(to & ito);

  // Channel status: count enable, terminal value and the resulting terminal event.
  always_comb begin
    tick     = '0;
    term     = '0;
    term_evt = '0;
    wr_hit   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      period_wide[c] = 64'(period[c]);
      snap_wide[c]   = 64'(snap[c]);
`ifdef PROFILE_TIMER_PRESCALER_EN
      tick[c] = run[c] && (pcnt[c] == prescale[c]);
`else
      tick[c] = run[c];
`endif
      term[c]     = dir[c] ? (cnt[c] == period[c]) : (cnt[c] == '0);
      term_evt[c] = tick[c] && term[c];
      wr_hit[c]   = wr && (sel_ch == 8'(c));
    end
  end

  // Channels beyond NUM_CH never match sel_ch, so they read as zero.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 8'(c)) begin
        case (sel_reg)
          REG_STATUS:   rd_val = {30'd0, run[c], to[c]};
          REG_CONTROL:  rd_val = {27'd0, dir[c], 2'b00, cont[c], ito[c]};
          REG_PERIOD_L: rd_val = period_wide[c][31:0];
          REG_PERIOD_H: rd_val = period_wide[c][63:32];
          REG_SNAP_L:   rd_val = snap_wide[c][31:0];
          REG_SNAP_H:   rd_val = snap_wide[c][63:32];
`ifdef PROFILE_TIMER_PRESCALER_EN
          REG_PRESCALE: rd_val = {16'd0, prescale[c]};
`endif
          default:      rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata     <= '0;
      run          <= '0;
      to           <= '0;
      ito          <= '0;
      cont         <= '0;
      dir          <= '0;
      force_reload <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]    <= RST_PERIOD;
        period[c] <= RST_PERIOD;
        snap[c]   <= '0;
`ifdef PROFILE_TIMER_PRESCALER_EN
        prescale[c] <= '0;
        pcnt[c]     <= '0;
`endif
      end
    end else begin
      readdata <= rd_val;
      for (int c = 0; c < NUM_CH; c++) begin
        force_reload[c] <= wr_hit[c] &&
                           ((sel_reg == REG_PERIOD_L) || ((sel_reg == REG_PERIOD_H) && (CNT_W > 32)));

        // A pending reload overrides counting and suppresses that edge's terminal event.
        if (force_reload[c]) begin
          cnt[c] <= dir[c] ? '0 : period[c];
          run[c] <= 1'b0;
`ifdef PROFILE_TIMER_PRESCALER_EN
          pcnt[c] <= '0;
`endif
        end else begin
          if (tick[c]) begin
            if (term[c])
              cnt[c] <= dir[c] ? '0 : period[c];
            else
              cnt[c] <= dir[c] ? cnt[c] + CNT_ONE : cnt[c] - CNT_ONE;
          end
          if (term_evt[c]) begin
            to[c] <= 1'b1;
            if (!cont[c])
              run[c] <= 1'b0;
          end
`ifdef PROFILE_TIMER_PRESCALER_EN
          if (!run[c] || tick[c])
            pcnt[c] <= '0;
          else
            pcnt[c] <= pcnt[c] + 16'd1;
`endif
        end

        // Register writes come last so a STATUS clear beats a same-edge terminal event.
        if (wr_hit[c]) begin
          case (sel_reg)
            REG_STATUS: to[c] <= 1'b0;
            REG_CONTROL: begin
              ito[c]  <= writedata[0];
              cont[c] <= writedata[1];
              dir[c]  <= writedata[4];
              if (writedata[3])
                run[c] <= 1'b0;
              if (writedata[2]) begin
                run[c] <= 1'b1;
`ifdef PROFILE_TIMER_PRESCALER_EN
                pcnt[c] <= '0;
`endif
              end
            end
            REG_PERIOD_L: period[c] <= CNT_W'({period_wide[c][63:32], writedata});
            REG_PERIOD_H: begin
              if (CNT_W > 32)
                period[c] <= CNT_W'({writedata, period_wide[c][31:0]});
            end
            REG_SNAP_L, REG_SNAP_H: snap[c] <= cnt[c];
`ifdef PROFILE_TIMER_PRESCALER_EN
            REG_PRESCALE: prescale[c] <= writedata[15:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule
